// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS encoder: transition minimisation, DC balance, and in HDMI
// mode a 10-cycle look-ahead that inserts the video preamble and guard band.
module tmds_encoder_mc #(
    parameter int         NUM_CH    = 3,
    parameter int         HDMI_MODE = 0,
    parameter logic [9:0] RST_SYM   = 10'b1101010100
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 de,
    input  logic [8*NUM_CH-1:0]  data_in,
    input  logic [2*NUM_CH-1:0]  ctl_in,
    output logic [10*NUM_CH-1:0] sym_out,
    output logic                 de_out,
    output logic                 gap_err
);
    // Blanking cycles that can be rewritten before each video period.
    localparam int LOOKAHEAD = 10;

    typedef enum logic [1:0] {
        OVR_NONE  = 2'd0,
        OVR_PRE   = 2'd1,
        OVR_GUARD = 2'd2
    } ovr_e;

    typedef struct packed {
        logic                de;
        logic [8*NUM_CH-1:0] data;
        logic [2*NUM_CH-1:0] ctl;
        ovr_e                ovr;
        logic                gerr;
    } tap_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Stage-1 transition minimisation; bit 8 flags the XOR chain.
    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    // Stage-2 DC balance; returns {symbol, next running disparity}.
    function automatic logic [14:0] balance(input logic [8:0] qm, input logic [4:0] cnt);
        logic [3:0] n1;
        logic [4:0] diff;
        logic [9:0] sym;
        logic [4:0] nxt;
        n1   = popcount8(qm[7:0]);
        diff = {n1, 1'b0} - 5'd8;
        if (cnt == 5'd0 || n1 == 4'd4) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nxt = qm[8] ? cnt + diff : cnt - diff;
        end else if ((!cnt[4] && n1 > 4'd4) || (cnt[4] && n1 < 4'd4)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + {3'b000, qm[8], 1'b0} - diff;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt - {3'b000, ~qm[8], 1'b0} + diff;
        end
        return {sym, nxt};
    endfunction

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] guard_sym(input int lane);
        return (lane == 1) ? 10'b0100110011 : 10'b1011001100;
    endfunction

    tap_t tap;

    generate
        if (HDMI_MODE != 0) begin : g_hdmi
            tap_t       dly    [LOOKAHEAD];
            tap_t       marked [LOOKAHEAD];
            logic [3:0] gap_cnt;
            logic       rise;

            // Tag the buffered blanking cycles that precede a rising de
            always_comb begin
                rise = de & ~dly[0].de;
                for (int k = 0; k < LOOKAHEAD; k++) begin
                    marked[k] = dly[k];
                    if (rise && k < int'(gap_cnt)) begin
                        marked[k].ovr  = (k < 2) ? OVR_GUARD : OVR_PRE;
                        marked[k].gerr = (int'(gap_cnt) < LOOKAHEAD) && (k == int'(gap_cnt) - 1);
                    end
                end
            end

            // Shift the look-ahead window and count the current blanking gap
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    // NOTE: the window is a shift register, not a RAM, so it is
                    // cleared here; reset must flush it to blanking with ctl=00.
                    for (int k = 0; k < LOOKAHEAD; k++) dly[k] <= '0;
                    gap_cnt <= '0;
                end else begin
                    dly[0] <= '{de: de, data: data_in, ctl: ctl_in, ovr: OVR_NONE, gerr: 1'b0};
                    for (int k = 1; k < LOOKAHEAD; k++) dly[k] <= marked[k-1];
                    if (de)
                        gap_cnt <= '0;
                    else if (gap_cnt != 4'(LOOKAHEAD))
                        gap_cnt <= gap_cnt + 4'd1;
                end
            end

            assign tap = marked[LOOKAHEAD-1];
        end else begin : g_dvi
            assign tap = '{de: de, data: data_in, ctl: ctl_in, ovr: OVR_NONE, gerr: 1'b0};
        end
    endgenerate

    logic [2*NUM_CH-1:0] ctl_eff;
    logic                s1_de;
    logic [2*NUM_CH-1:0] s1_ctl;
    ovr_e                s1_ovr;
    logic                s1_gerr;
    logic [8:0]          s1_qm  [NUM_CH];
    logic [9:0]          sym_q  [NUM_CH];
    logic [4:0]          cnt_q  [NUM_CH];

    // Preamble forces lane 1 to CTL 01 and lane 2 to CTL 00
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        ctl_eff = tap.ctl;
        if (tap.ovr == OVR_PRE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (k == 1)      ctl_eff[2*k +: 2] = 2'b01;
                else if (k == 2) ctl_eff[2*k +: 2] = 2'b00;
            end
        end
    end

    // Stage 1: register the minimised words and the control context
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_de   <= 1'b0;
            s1_ctl  <= '0;
            s1_ovr  <= OVR_NONE;
            s1_gerr <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) s1_qm[k] <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples pre-edge values together.
            s1_de   <= tap.de;
            s1_ctl  <= ctl_eff;
            s1_ovr  <= tap.ovr;
            s1_gerr <= tap.gerr;
            for (int k = 0; k < NUM_CH; k++) s1_qm[k] <= minimise(tap.data[8*k +: 8]);
        end
    end

    // Stage 2: DC-balance video or emit control/guard symbols, clear disparity
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            de_out  <= 1'b0;
            gap_err <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                sym_q[k] <= RST_SYM;
                cnt_q[k] <= '0;
            end
        end else begin
            de_out  <= s1_de;
            gap_err <= s1_gerr;
            for (int k = 0; k < NUM_CH; k++) begin
                if (s1_de) begin
                    {sym_q[k], cnt_q[k]} <= balance(s1_qm[k], cnt_q[k]);
                end else begin
                    sym_q[k] <= (s1_ovr == OVR_GUARD) ? guard_sym(k) : ctl_sym(s1_ctl[2*k +: 2]);
                    cnt_q[k] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign sym_out[10*g +: 10] = sym_q[g];
    end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Directed bench: one DVI and one HDMI instance share the stimulus; each
// output is compared LAT cycles after its input against hand-computed symbols.
module tb_tmds_encoder_mc;
    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] G0  = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;
    localparam logic [9:0] Z0  = 10'b0100000000; // 0x00 with cnt>=0
    localparam logic [9:0] Z1  = 10'b1111111111; // 0x00 with cnt<0
    localparam logic [9:0] F0  = 10'b1000000000; // 0xFF with cnt==0 or cnt>0
    localparam logic [9:0] F1  = 10'b0011111111; // 0xFF with cnt<0
    localparam logic [9:0] V55 = 10'b0100110011;
    localparam logic [9:0] VAA = 10'b1000110011;
    localparam logic [9:0] V01 = 10'b0111111111; // 0x01 at cnt 0
    localparam logic [9:0] V01B = 10'b1100000000; // 0x01 at cnt +8

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        de;
    logic [23:0] data_in;
    logic [5:0]  ctl_in;
    logic [29:0] dvi_sym, hdmi_sym;
    logic        dvi_de_out, hdmi_de_out, dvi_gap_err, hdmi_gap_err;

    always #5 sys_clk = ~sys_clk;

    tmds_encoder_mc #(.NUM_CH(3), .HDMI_MODE(0)) u_dvi (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .de(de), .data_in(data_in), .ctl_in(ctl_in),
        .sym_out(dvi_sym), .de_out(dvi_de_out), .gap_err(dvi_gap_err));

    tmds_encoder_mc #(.NUM_CH(3), .HDMI_MODE(1)) u_hdmi (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .de(de), .data_in(data_in), .ctl_in(ctl_in),
        .sym_out(hdmi_sym), .de_out(hdmi_de_out), .gap_err(hdmi_gap_err));

    typedef struct {
        bit         chk;
        logic [9:0] s [3];
        logic       de;
        logic       gerr;
        string      tag;
    } exp_t;

    exp_t q_dvi[$];
    exp_t q_hdmi[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t ex(input bit chk, input logic [9:0] a, input logic [9:0] b,
                                input logic [9:0] c, input logic d, input logic g, input string t);
        exp_t e;
        e.chk = chk; e.s[0] = a; e.s[1] = b; e.s[2] = c; e.de = d; e.gerr = g; e.tag = t;
        return e;
    endfunction

    function automatic exp_t none();
        return ex(1'b0, '0, '0, '0, 1'b0, 1'b0, "none");
    endfunction

    task automatic check_out(input string who, input logic [29:0] sym, input logic de_o,
                             input logic gerr_o, input exp_t e);
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            assert (sym[10*k +: 10] === e.s[k]) else begin
                n_fail++;
                $error("FAIL %s/%s lane%0d sym observed=%b expected=%b", who, e.tag, k, sym[10*k +: 10], e.s[k]);
            end
        end
        n_assert++;
        assert (de_o === e.de) else begin
            n_fail++;
            $error("FAIL %s/%s de_out observed=%b expected=%b", who, e.tag, de_o, e.de);
        end
        n_assert++;
        assert (gerr_o === e.gerr) else begin
            n_fail++;
            $error("FAIL %s/%s gap_err observed=%b expected=%b", who, e.tag, gerr_o, e.gerr);
        end
    endtask

    // One clock; retire the expectation that has reached each output.
    task automatic tick();
        exp_t e;
        @(posedge sys_clk);
        #1;
        if (q_dvi.size() >= 2) begin
            e = q_dvi.pop_front();
            if (e.chk) check_out("dvi", dvi_sym, dvi_de_out, dvi_gap_err, e);
        end
        if (q_hdmi.size() >= 12) begin
            e = q_hdmi.pop_front();
            if (e.chk) check_out("hdmi", hdmi_sym, hdmi_de_out, hdmi_gap_err, e);
        end
    endtask

    task automatic step(input logic de_i, input logic [23:0] d, input logic [5:0] c,
                        input exp_t ed, input exp_t eh);
        de      = de_i;
        data_in = d;
        ctl_in  = c;
        q_dvi.push_back(ed);
        q_hdmi.push_back(eh);
        tick();
    endtask

    task automatic do_reset(input string tag);
        q_dvi.delete();
        q_hdmi.delete();
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            de      = 1'($urandom);
            data_in = 24'($urandom);
            ctl_in  = 6'($urandom);
            @(posedge sys_clk);
            #1;
            check_out("dvi", dvi_sym, dvi_de_out, dvi_gap_err, ex(1, C00, C00, C00, 0, 0, tag));
            check_out("hdmi", hdmi_sym, hdmi_de_out, hdmi_gap_err, ex(1, C00, C00, C00, 0, 0, tag));
        end
        sys_rst = 1'b0;
        // Until the first post-release input arrives, the flushed pipeline shows ctl 00.
        q_dvi.push_back(ex(1, C00, C00, C00, 0, 0, "post_rst"));
        for (int i = 0; i < 11; i++) q_hdmi.push_back(ex(1, C00, C00, C00, 0, 0, "post_rst"));
    endtask

    initial begin
        sys_rst = 1'b1;
        de      = 1'b0;
        data_in = '0;
        ctl_in  = '0;
        do_reset("rst_init");

        // ---- DVI: control codes on lane 0, lanes 1/2 held at 11 ----
        step(0, 24'h0, 6'b11_11_00, ex(1, C00, C11, C11, 0, 0, "ctl00"), none());
        step(0, 24'h0, 6'b11_11_01, ex(1, C01, C11, C11, 0, 0, "ctl01"), none());
        step(0, 24'h0, 6'b11_11_10, ex(1, C10, C11, C11, 0, 0, "ctl10"), none());
        step(0, 24'h0, 6'b01_00_11, ex(1, C11, C00, C01, 0, 0, "ctl_mix"), none());
        // ---- DVI: 0x00 disparity walk, cnt -8, +2, -6 ----
        step(1, 24'h000000, 6'b0, ex(1, Z0, Z0, Z0, 1, 0, "zero_a"), none());
        step(1, 24'h000000, 6'b0, ex(1, Z1, Z1, Z1, 1, 0, "zero_b"), none());
        step(1, 24'h000000, 6'b0, ex(1, Z0, Z0, Z0, 1, 0, "zero_c"), none());
        step(0, 24'h000000, 6'b0, ex(1, C00, C00, C00, 0, 0, "blank1"), none());
        // ---- DVI: balanced and unbalanced words, independent lanes ----
        step(1, 24'h01AA55, 6'b0, ex(1, V55, VAA, V01, 1, 0, "mix_a"), none());
        step(1, 24'h01AA55, 6'b0, ex(1, V55, VAA, V01B, 1, 0, "mix_b"), none());
        step(0, 24'h000000, 6'b0, ex(1, C00, C00, C00, 0, 0, "blank2"), none());
        // ---- DVI: 0xFF run, 1-cycle gap, disparity must restart at 0 ----
        step(1, 24'hFFFFFF, 6'b0, ex(1, F0, F0, F0, 1, 0, "ff1"), none());
        step(1, 24'hFFFFFF, 6'b0, ex(1, F1, F1, F1, 1, 0, "ff2"), none());
        step(1, 24'hFFFFFF, 6'b0, ex(1, F1, F1, F1, 1, 0, "ff3"), none());
        step(1, 24'hFFFFFF, 6'b0, ex(1, F0, F0, F0, 1, 0, "ff4"), none());
        step(1, 24'hFFFFFF, 6'b0, ex(1, F1, F1, F1, 1, 0, "ff5"), none());
        step(0, 24'h000000, 6'b0, ex(1, C00, C00, C00, 0, 0, "gap_a"), none());
        step(1, 24'h000000, 6'b0, ex(1, Z0, Z0, Z0, 1, 0, "clr_zero"), none());
        step(0, 24'h000000, 6'b0, ex(1, C00, C00, C00, 0, 0, "gap_b"), none());
        step(1, 24'hFFFFFF, 6'b0, ex(1, F0, F0, F0, 1, 0, "ff_neg8"), none());
        step(0, 24'h000000, 6'b0, ex(1, C00, C00, C00, 0, 0, "gap_c"), none());
        step(1, 24'hFFFFFF, 6'b0, ex(1, F0, F0, F0, 1, 0, "clr_ff"), none());
        step(1, 24'h123456, 6'b0, none(), none());

        // ---- Reset in the middle of active video ----
        do_reset("rst_mid");

        // ---- HDMI: 20-cycle gap -> 10 plain, 8 preamble, 2 guard ----
        for (int i = 0; i < 10; i++)
            step(0, 24'h0, 6'b11_11_10, none(), ex(1, C10, C11, C11, 0, 0, "h_ctl"));
        for (int i = 0; i < 8; i++)
            step(0, 24'h0, 6'b11_11_10, none(), ex(1, C10, C01, C00, 0, 0, "h_pre"));
        for (int i = 0; i < 2; i++)
            step(0, 24'h0, 6'b11_11_10, none(), ex(1, G0, G1, G0, 0, 0, "h_guard"));
        step(1, 24'h01AA55, 6'b11_11_10, none(), ex(1, V55, VAA, V01, 1, 0, "h_vid_a"));
        step(1, 24'h01AA55, 6'b11_11_10, none(), ex(1, V55, VAA, V01B, 1, 0, "h_vid_b"));
        // ---- HDMI: 5-cycle gap -> 3 preamble + 2 guard, gap_err on first ----
        step(0, 24'h0, 6'b11_11_01, none(), ex(1, C01, C01, C00, 0, 1, "h_short_pre0"));
        step(0, 24'h0, 6'b11_11_01, none(), ex(1, C01, C01, C00, 0, 0, "h_short_pre1"));
        step(0, 24'h0, 6'b11_11_01, none(), ex(1, C01, C01, C00, 0, 0, "h_short_pre2"));
        step(0, 24'h0, 6'b11_11_01, none(), ex(1, G0, G1, G0, 0, 0, "h_short_g0"));
        step(0, 24'h0, 6'b11_11_01, none(), ex(1, G0, G1, G0, 0, 0, "h_short_g1"));
        step(1, 24'hFFFFFF, 6'b11_11_01, none(), ex(1, F0, F0, F0, 1, 0, "h_vid_ff"));
        // ---- HDMI: 1-cycle gap -> single guard cycle with gap_err ----
        step(0, 24'h0, 6'b11_11_01, none(), ex(1, G0, G1, G0, 0, 1, "h_gap1"));
        step(1, 24'h000000, 6'b11_11_01, none(), ex(1, Z0, Z0, Z0, 1, 0, "h_vid_zero"));
        for (int i = 0; i < 12; i++)
            step(0, 24'h0, 6'b11_11_01, none(), ex(1, C01, C11, C11, 0, 0, "h_tail"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
